// File: rtl/player_damage_ctrl.sv
// player_damage_ctrl
// Turns the per-frame player/tree collision flag into game state. It
// decrements lives, opens a timed invulnerability window with a blinking
// sprite mask, and raises game-over when the last life is lost.
//
// Parameters:
//   START_LIVES   lives loaded on reset/restart (1..7)
//   INVULN_FRAMES frames of invulnerability after a non-fatal hit (>=1)
//   BLINK_FRAMES  frames per visibility toggle while invulnerable (>=1)
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   startOfFrame   one-cycle pulse per video frame
//   hitPulse       collision level (first colliding pixel .. next frame)
//   restart        one-cycle new-game request
//   lives          remaining lives
//   invulnerable   hits currently ignored
//   playerVisible  sprite enable mask
//   damageStrobe   one-cycle pulse per accepted hit
//   gameOver       lives exhausted, held until restart/reset
module player_damage_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       hitPulse,
  input  logic       restart,
  output logic [2:0] lives,
  output logic       invulnerable,
  output logic       playerVisible,
  output logic       damageStrobe,
  output logic       gameOver
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0] INV_ONE    = INV_W'(1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_ONE    = BLK_W'(1);
  localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);

  typedef enum logic [1:0] {ALIVE, INVULN, GAME_OVER} state_e;

  state_e           state_q, state_d;
  logic             hit_prev_q, hit_prev_d;
  logic [2:0]       lives_q, lives_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             vis_q, vis_d;
  logic             strobe_q, strobe_d;
  logic             invuln_q, invuln_d;
  logic             game_over_q, game_over_d;
  logic             hit_edge;

  // Only a rising edge of the level counts; a level left over from an
  // earlier edge (e.g. held across the end of invulnerability) is ignored.
  assign hit_edge = hitPulse & ~hit_prev_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    blink_cnt_d = blink_cnt_q;
    vis_d       = vis_q;
    strobe_d    = 1'b0;
    hit_prev_d  = hitPulse;

    if (restart) begin
      // New game wins over any hit in the same cycle.
      state_d     = ALIVE;
      lives_d     = LIVES_INIT;
      inv_cnt_d   = '0;
      blink_cnt_d = '0;
      vis_d       = 1'b1;
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit_edge) begin
            strobe_d = 1'b1;
            vis_d    = 1'b0;
            if (lives_q > 3'd1) begin
              lives_d     = lives_q - 3'd1;
              state_d     = INVULN;
              inv_cnt_d   = INV_LOAD;
              blink_cnt_d = '0;
            end else begin
              lives_d = 3'd0;
              state_d = GAME_OVER;
            end
          end
        end
        INVULN: begin
          if (startOfFrame) begin
            if (inv_cnt_q == INV_ONE) begin
              // Last frame of the window: back to normal, fully visible.
              state_d     = ALIVE;
              inv_cnt_d   = '0;
              blink_cnt_d = '0;
              vis_d       = 1'b1;
            end else begin
              inv_cnt_d = inv_cnt_q - INV_ONE;
              if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                vis_d       = ~vis_q;
              end else begin
                blink_cnt_d = blink_cnt_q + BLK_ONE;
              end
            end
          end
        end
        GAME_OVER: begin
          vis_d   = 1'b0;
          lives_d = 3'd0;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end

    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ALIVE;
      hit_prev_q  <= 1'b0;
      lives_q     <= LIVES_INIT;
      inv_cnt_q   <= '0;
      blink_cnt_q <= '0;
      vis_q       <= 1'b1;
      strobe_q    <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_prev_q  <= hit_prev_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      vis_q       <= vis_d;
      strobe_q    <= strobe_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign lives         = lives_q;
  assign invulnerable  = invuln_q;
  assign playerVisible = vis_q;
  assign damageStrobe  = strobe_q;
  assign gameOver      = game_over_q;

endmodule

// File: tb/tb_player_damage_ctrl.sv
// Testbench for player_damage_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// frame-counting behavioural model.
module tb_player_damage_ctrl;

  localparam int SL  = 3;
  localparam int INV = 5;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       hitPulse = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] lives;
  logic       invulnerable, playerVisible, damageStrobe, gameOver;

  player_damage_ctrl #(.START_LIVES(SL), .INVULN_FRAMES(INV), .BLINK_FRAMES(BLK)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hitPulse(hitPulse),
    .restart(restart), .lives(lives), .invulnerable(invulnerable),
    .playerVisible(playerVisible), .damageStrobe(damageStrobe), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  bit cmp_en = 1'b0;

  // Model: remaining invulnerable frames and frames elapsed since the hit.
  int m_lives = SL, m_left = 0, m_elapsed = 0;
  bit m_over = 0, m_strobe = 0, m_prev = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_vis();
    if (m_over) return 1'b0;
    if (m_left > 0) return ((m_elapsed / BLK) % 2) == 1;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit edge_hit;
    edge_hit = hitPulse && !m_prev;
    m_strobe = 0;
    if (reset) begin
      m_lives = SL; m_left = 0; m_elapsed = 0; m_over = 0; m_prev = 0;
    end else begin
      if (restart) begin
        m_lives = SL; m_left = 0; m_elapsed = 0; m_over = 0;
      end else if (m_over) begin
        // hits ignored
      end else if (m_left > 0) begin
        if (startOfFrame) begin
          m_left--;
          m_elapsed++;
        end
      end else if (edge_hit) begin
        m_strobe = 1;
        if (m_lives > 1) begin
          m_lives--; m_left = INV; m_elapsed = 0;
        end else begin
          m_lives = 0; m_over = 1;
        end
      end
      m_prev = hitPulse;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("lives", 8'(lives), 8'(m_lives));
      chk("invulnerable", 8'(invulnerable), 8'(m_left > 0));
      chk("playerVisible", 8'(playerVisible), 8'(m_vis()));
      chk("damageStrobe", 8'(damageStrobe), 8'(m_strobe));
      chk("gameOver", 8'(gameOver), 8'(m_over));
      if (damageStrobe === 1'b1) strobes++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
  endtask

  initial begin
    int s0;
    bit prev_sof;
    cyc(2);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_vis", 8'(playerVisible), 8'd1);
    chk("rst_over", 8'(gameOver), 8'd0);
    chk("rst_inv", 8'(invulnerable), 8'd0);

    // Held hit level for 10 cycles gives exactly one strobe
    s0 = strobes;
    hitPulse = 1'b1;
    cyc(10);
    hitPulse = 1'b0;
    cyc(2);
    chk("hold_strobes", 8'(strobes - s0), 8'd1);
    chk("hit_lives", 8'(lives), 8'd2);
    chk("hit_inv", 8'(invulnerable), 8'd1);
    chk("hit_vis", 8'(playerVisible), 8'd0);

    // 5-frame window, toggles after pulses 2 and 4, hits ignored inside
    s0 = strobes;
    for (int p = 1; p <= 5; p++) begin
      frame();
      case (p)
        1: chk("blink_p1", 8'(playerVisible), 8'd0);
        2: chk("blink_p2", 8'(playerVisible), 8'd1);
        3: chk("blink_p3", 8'(playerVisible), 8'd1);
        4: chk("blink_p4", 8'(playerVisible), 8'd0);
        default: begin
          chk("expire_inv", 8'(invulnerable), 8'd0);
          chk("expire_vis", 8'(playerVisible), 8'd1);
        end
      endcase
      if (p < 5) begin
        hitPulse = 1'b1; cyc();
        hitPulse = 1'b0; cyc();
      end
    end
    chk("inv_strobes", 8'(strobes - s0), 8'd0);
    chk("inv_lives", 8'(lives), 8'd2);

    // Lives 1 in INVULN, then restart coinciding with a hit edge
    hitPulse = 1'b1; cyc();
    hitPulse = 1'b0; cyc();
    chk("pre_restart_lives", 8'(lives), 8'd1);
    s0 = strobes;
    hitPulse = 1'b1; restart = 1'b1; cyc();
    chk("restart_lives", 8'(lives), 8'd3);
    chk("restart_inv", 8'(invulnerable), 8'd0);
    chk("restart_strobe", 8'(damageStrobe), 8'd0);
    chk("restart_over", 8'(gameOver), 8'd0);
    restart = 1'b0; hitPulse = 1'b0; cyc();
    chk("restart_nostrobe", 8'(strobes - s0), 8'd0);

    // Hit held from frame 4 across expiry: no hit until a new edge
    hitPulse = 1'b1; cyc();
    hitPulse = 1'b0; cyc();
    frame(); frame(); frame();
    hitPulse = 1'b1;
    s0 = strobes;
    frame(); frame();
    cyc(3);
    chk("held_strobes", 8'(strobes - s0), 8'd0);
    chk("held_lives", 8'(lives), 8'd2);
    hitPulse = 1'b0; cyc();
    hitPulse = 1'b1; cyc();
    chk("reedge_lives", 8'(lives), 8'd1);
    chk("reedge_strobe", 8'(damageStrobe), 8'd1);
    hitPulse = 1'b0;

    // Expire and take the fatal hit
    repeat (5) frame();
    hitPulse = 1'b1; cyc();
    chk("fatal_lives", 8'(lives), 8'd0);
    chk("fatal_over", 8'(gameOver), 8'd1);
    chk("fatal_vis", 8'(playerVisible), 8'd0);
    chk("fatal_strobe", 8'(damageStrobe), 8'd1);
    hitPulse = 1'b0; cyc();
    s0 = strobes;
    repeat (3) begin
      hitPulse = 1'b1; cyc();
      hitPulse = 1'b0; cyc();
    end
    chk("over_strobes", 8'(strobes - s0), 8'd0);

    // Reset from GAME_OVER
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk("rst2_lives", 8'(lives), 8'd3);
    chk("rst2_over", 8'(gameOver), 8'd0);
    chk("rst2_vis", 8'(playerVisible), 8'd1);
    chk("rst2_strobe", 8'(damageStrobe), 8'd0);

    // Randomized traffic; hit level normally drops after a frame pulse
    prev_sof = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 399) == 0);
      restart      = ($urandom_range(0, 99) == 0);
      if (prev_sof && $urandom_range(0, 3) != 0) hitPulse = 1'b0;
      else if (!hitPulse && $urandom_range(0, 7) == 0) hitPulse = 1'b1;
      startOfFrame = ($urandom_range(0, 4) == 0);
      prev_sof     = startOfFrame;
      cyc();
    end
    reset = 1'b0; restart = 1'b0; hitPulse = 1'b0; startOfFrame = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
